// File: rtl/cbx_cfg_pkg.sv
// ----------------------------------------------------------------------------
// cbx_cfg_pkg
//   Shared sizing and helpers for the cbx_1__3_cfg horizontal connection
//   block and its pin multiplexers.
//   - CHAN_W   : tracks per direction on the X channel
//   - NUM_PINS : grid input pins driven by the block
//   - MUX_SIZE : candidate tracks per pin mux
//   - SEL_W    : select bits per pin (2**SEL_W must cover MUX_SIZE)
//   - CFG_W    : total configuration chain length
//   - CNT_W    : width of the shift counter (counts 0..CFG_W)
// ----------------------------------------------------------------------------
package cbx_cfg_pkg;

  localparam int CHAN_W   = 20;
  localparam int NUM_PINS = 4;
  localparam int MUX_SIZE = 10;
  localparam int SEL_W    = 4;
  localparam int CFG_W    = NUM_PINS * SEL_W;
  localparam int CNT_W    = $clog2(CFG_W + 1);

  typedef logic [SEL_W-1:0] sel_t;

  // Track tapped by pin p when its select value is s.
  function automatic int track_idx(input int p, input int s);
    return (2 * s + p) % CHAN_W;
  endfunction

endpackage

// File: rtl/cbx_pin_mux.sv
// ----------------------------------------------------------------------------
// cbx_pin_mux
//   MUX_SIZE:1 binary-encoded multiplexer for one grid input pin.
//   Select values at or beyond MUX_SIZE drive a constant 0.
//   Ports:
//     cand_i : candidate tracks, cand_i[s] is chosen by sel_i == s
//     sel_i  : binary select
//     pin_o  : selected track value
// ----------------------------------------------------------------------------
module cbx_pin_mux
  import cbx_cfg_pkg::*;
(
  input  logic [MUX_SIZE-1:0] cand_i,
  input  sel_t                sel_i,
  output logic                pin_o
);

  // NOTE: pin_o is given a default before the loop so every select value,
  // including the unused encodings, assigns it and no latch is inferred.
  always_comb begin
    pin_o = 1'b0;
    for (int s = 0; s < MUX_SIZE; s++) begin
      if (sel_i == SEL_W'(s)) begin
        pin_o = cand_i[s];
      end
    end
  end

endmodule

// File: rtl/cbx_1__3_cfg.sv
// ----------------------------------------------------------------------------
// cbx_1__3_cfg
//   Horizontal (X-channel) connection block, tile column 1 / row 3.
//   - chanx tracks pass left<->right combinationally.
//   - NUM_PINS grid pins are tapped from chanx_left_in via binary muxes whose
//     selects are held in a CFG_W-bit configuration flip-flop shift chain.
//   - A shift counter raises config_done once exactly CFG_W bits have been
//     shifted; until then the grid pins are forced to 0.
//
//   Optional build macro CBX_CCFF_SHADOW_EN:
//     When defined, a shadow copy of the chain is captured on each completed
//     pass and the muxes decode the shadow, so pins keep driving the last
//     complete configuration while a new one is shifted in. Pins are gated
//     only until the first completed pass after reset.
//
//   Ports:
//     prog_clk        : configuration clock (only clock)
//     pReset          : asynchronous active-high reset
//     chanx_left_in   : tracks entering from the left
//     chanx_right_in  : tracks entering from the right
//     chanx_left_out  : tracks leaving to the left  (= chanx_right_in)
//     chanx_right_out : tracks leaving to the right (= chanx_left_in)
//     ccff_head       : serial configuration data in
//     ccff_en         : shift enable, one bit per prog_clk edge
//     ccff_tail       : serial configuration data out (last chain stage)
//     top_grid_pin    : grid pin drives
//     config_done     : high when exactly CFG_W bits shifted since restart
// ----------------------------------------------------------------------------
module cbx_1__3_cfg
  import cbx_cfg_pkg::*;
(
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic [0:CHAN_W-1]   chanx_left_in,
  input  logic [0:CHAN_W-1]   chanx_right_in,
  output logic [0:CHAN_W-1]   chanx_left_out,
  output logic [0:CHAN_W-1]   chanx_right_out,
  input  logic                ccff_head,
  input  logic                ccff_en,
  output logic                ccff_tail,
  output logic [0:NUM_PINS-1] top_grid_pin,
  output logic                config_done
);

  // --------------------------------------------------------------------------
  // Pass-through
  // --------------------------------------------------------------------------
  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  // --------------------------------------------------------------------------
  // Configuration chain and shift counter
  // --------------------------------------------------------------------------
  logic [0:CFG_W-1] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    if (ccff_en) begin
      cfg_d = {ccff_head, cfg_q[0:CFG_W-2]};
      // A shift after a completed pass starts the next pass at count 1.
      if (cnt_q == CNT_W'(CFG_W)) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes the chain shift by one stage.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cfg_q <= '0;
      cnt_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
    end
  end

  assign config_done = (cnt_q == CNT_W'(CFG_W));
  assign ccff_tail   = cfg_q[CFG_W-1];

  // --------------------------------------------------------------------------
  // Configuration seen by the muxes, and the pin enable
  // --------------------------------------------------------------------------
  logic [0:CFG_W-1] dec_cfg;
  logic             pins_valid;

`ifdef CBX_CCFF_SHADOW_EN
  logic [0:CFG_W-1] shadow_q, shadow_d;
  logic             armed_q, armed_d;

  // Capture on the shift that brings cnt to CFG_W, taking the post-shift
  // chain contents so the shadow holds the just-completed configuration.
  always_comb begin
    shadow_d = shadow_q;
    armed_d  = armed_q;
    if (ccff_en && (cnt_q == CNT_W'(CFG_W - 1))) begin
      shadow_d = cfg_d;
      armed_d  = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      armed_q  <= armed_d;
    end
  end

  assign dec_cfg    = shadow_q;
  assign pins_valid = armed_q;
`else
  assign dec_cfg    = cfg_q;
  assign pins_valid = config_done;
`endif

  // --------------------------------------------------------------------------
  // Pin muxes: pin p picks chanx_left_in[(2*s + p) mod CHAN_W] for select s
  // --------------------------------------------------------------------------
  logic [0:NUM_PINS-1] mux_out;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [MUX_SIZE-1:0] cand;

    for (genvar s = 0; s < MUX_SIZE; s++) begin : g_cand
      assign cand[s] = chanx_left_in[track_idx(p, s)];
    end

    // The lower chain index of each field is the select MSB.
    cbx_pin_mux u_mux (
      .cand_i (cand),
      .sel_i  (dec_cfg[p*SEL_W +: SEL_W]),
      .pin_o  (mux_out[p])
    );

    assign top_grid_pin[p] = pins_valid & mux_out[p];
  end

endmodule

// File: tb/tb_cbx_1__3_cfg.sv
// ----------------------------------------------------------------------------
// tb_cbx_1__3_cfg
//   Directed self-checking bench for cbx_1__3_cfg. Configurations are written
//   as [0:CFG_W-1] chain images; the last bit shifted lands in cfg[0], so a
//   full load shifts image[CFG_W-1] first and image[0] last.
// ----------------------------------------------------------------------------
module tb_cbx_1__3_cfg;
  import cbx_cfg_pkg::*;

  logic                prog_clk = 1'b0;
  logic                pReset;
  logic [0:CHAN_W-1]   chanx_left_in;
  logic [0:CHAN_W-1]   chanx_right_in;
  logic [0:CHAN_W-1]   chanx_left_out;
  logic [0:CHAN_W-1]   chanx_right_out;
  logic                ccff_head;
  logic                ccff_en;
  logic                ccff_tail;
  logic [0:NUM_PINS-1] top_grid_pin;
  logic                config_done;

  int total = 0;
  int bad   = 0;

  // sel0=3, sel1=0, sel2=9, sel3=15
  localparam logic [0:CFG_W-1] CFG_A = {4'd3, 4'd0, 4'd9, 4'd15};
  // sel0=5 (track 10), others 0
  localparam logic [0:CFG_W-1] CFG_B = {4'd5, 4'd0, 4'd0, 4'd0};

  cbx_1__3_cfg dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ccff_head       (ccff_head),
    .ccff_en         (ccff_en),
    .ccff_tail       (ccff_tail),
    .top_grid_pin    (top_grid_pin),
    .config_done     (config_done)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  function automatic logic [0:CHAN_W-1] onehot(input int i);
    logic [0:CHAN_W-1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ------------------------------------------------------------------ stimulus
  task automatic do_reset();
    @(negedge prog_clk);
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    pReset    = 1'b1;
    @(negedge prog_clk);
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  // One enabled shift; outputs are settled and sampled #1 after the edge.
  task automatic shift_bit(input logic b);
    @(negedge prog_clk);
    ccff_head = b;
    ccff_en   = 1'b1;
    @(posedge prog_clk);
    #1;
    ccff_en = 1'b0;
  endtask

  // Shift image[hi] down to image[lo].
  task automatic shift_seq(input logic [0:CFG_W-1] image, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) shift_bit(image[k]);
  endtask

  // --------------------------------------------------------------------- tests
  task automatic test_reset();
    pReset         = 1'b1;
    ccff_en        = 1'b0;
    ccff_head      = 1'b0;
    chanx_left_in  = 20'hA5A5A;
    chanx_right_in = 20'h0F0F0;
    #12;
    total++; if (chanx_right_out !== 20'hA5A5A) begin bad++;
      $display("FAIL reset_pass_right: got=%h exp=%h", chanx_right_out, 20'hA5A5A); end
    total++; if (chanx_left_out !== 20'h0F0F0) begin bad++;
      $display("FAIL reset_pass_left: got=%h exp=%h", chanx_left_out, 20'h0F0F0); end
    total++; if (top_grid_pin !== 4'b0000) begin bad++;
      $display("FAIL reset_pins: got=%b exp=0000", top_grid_pin); end
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL reset_done: got=%b exp=0", config_done); end
    total++; if (ccff_tail !== 1'b0) begin bad++;
      $display("FAIL reset_tail: got=%b exp=0", ccff_tail); end
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  task automatic test_full_load();
    do_reset();
    chanx_left_in = onehot(6);
    shift_seq(CFG_A, CFG_W-1, 0);
    total++; if (config_done !== 1'b1) begin bad++;
      $display("FAIL load_done: got=%b exp=1", config_done); end
    // First bit shifted (image[15]=1) now sits in the last stage.
    total++; if (ccff_tail !== 1'b1) begin bad++;
      $display("FAIL load_tail: got=%b exp=1", ccff_tail); end
    total++; if (top_grid_pin !== 4'b1000) begin bad++;
      $display("FAIL load_track6: got=%b exp=1000", top_grid_pin); end
    chanx_left_in = onehot(1); #1;
    total++; if (top_grid_pin !== 4'b0100) begin bad++;
      $display("FAIL load_track1: got=%b exp=0100", top_grid_pin); end
    chanx_left_in = onehot(0); #1;
    total++; if (top_grid_pin !== 4'b0010) begin bad++;
      $display("FAIL load_track0: got=%b exp=0010", top_grid_pin); end
    // pin3 select 15 is out of range and must stay 0 even with all tracks high.
    chanx_left_in = '1; #1;
    total++; if (top_grid_pin !== 4'b1110) begin bad++;
      $display("FAIL load_all_ones: got=%b exp=1110", top_grid_pin); end
  endtask

  task automatic test_gating();
    do_reset();
    chanx_left_in = '1;
    shift_seq(CFG_A, CFG_W-1, 1);
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL gate_done15: got=%b exp=0", config_done); end
    total++; if (top_grid_pin !== 4'b0000) begin bad++;
      $display("FAIL gate_pins15: got=%b exp=0000", top_grid_pin); end
    repeat (5) @(posedge prog_clk);
    #1;
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL gate_hold_done: got=%b exp=0", config_done); end
    total++; if (ccff_tail !== 1'b0) begin bad++;
      $display("FAIL gate_hold_tail: got=%b exp=0", ccff_tail); end
    shift_bit(CFG_A[0]);
    total++; if (config_done !== 1'b1) begin bad++;
      $display("FAIL gate_done16: got=%b exp=1", config_done); end
    total++; if (top_grid_pin !== 4'b1110) begin bad++;
      $display("FAIL gate_pins16: got=%b exp=1110", top_grid_pin); end
  endtask

  task automatic test_tail_latency();
    do_reset();
    shift_bit(1'b1);
    repeat (CFG_W - 2) shift_bit(1'b0);
    total++; if (ccff_tail !== 1'b0) begin bad++;
      $display("FAIL tail_edge15: got=%b exp=0", ccff_tail); end
    shift_bit(1'b0);
    total++; if (ccff_tail !== 1'b1) begin bad++;
      $display("FAIL tail_edge16: got=%b exp=1", ccff_tail); end
    total++; if (config_done !== 1'b1) begin bad++;
      $display("FAIL tail_done16: got=%b exp=1", config_done); end
    shift_bit(1'b0);
    total++; if (ccff_tail !== 1'b0) begin bad++;
      $display("FAIL tail_edge17: got=%b exp=0", ccff_tail); end
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL tail_wrap_done: got=%b exp=0", config_done); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    chanx_left_in = '1;
    repeat (CFG_W + 8) shift_bit(1'b1);
    total++; if (ccff_tail !== 1'b1) begin bad++;
      $display("FAIL midrst_pre_tail: got=%b exp=1", ccff_tail); end
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL midrst_pre_done: got=%b exp=0", config_done); end
    // Assert reset between edges and look before any clock edge.
    @(negedge prog_clk);
    #2 pReset = 1'b1;
    #1;
    total++; if (ccff_tail !== 1'b0) begin bad++;
      $display("FAIL midrst_tail: got=%b exp=0", ccff_tail); end
    total++; if (top_grid_pin !== 4'b0000) begin bad++;
      $display("FAIL midrst_pins: got=%b exp=0000", top_grid_pin); end
    // Reset held while shifting: reset wins.
    ccff_head = 1'b1;
    ccff_en   = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    total++; if ({ccff_tail, config_done} !== 2'b00) begin bad++;
      $display("FAIL midrst_reset_wins: got=%b exp=00", {ccff_tail, config_done}); end
    @(negedge prog_clk);
    ccff_en = 1'b0;
    pReset  = 1'b0;
    total++; if (chanx_right_out !== '1) begin bad++;
      $display("FAIL midrst_pass: got=%h exp=fffff", chanx_right_out); end
    shift_seq(CFG_A, CFG_W-1, 1);
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL midrst_done15: got=%b exp=0", config_done); end
    shift_bit(CFG_A[0]);
    total++; if (config_done !== 1'b1) begin bad++;
      $display("FAIL midrst_done16: got=%b exp=1", config_done); end
    total++; if (top_grid_pin !== 4'b1110) begin bad++;
      $display("FAIL midrst_pins16: got=%b exp=1110", top_grid_pin); end
  endtask

  task automatic test_reshift();
    logic [0:NUM_PINS-1] exp_mid6, exp_mid10;
`ifdef CBX_CCFF_SHADOW_EN
    exp_mid6  = 4'b1000;  // still decoding config A
    exp_mid10 = 4'b0000;
`else
    exp_mid6  = 4'b0000;  // gated while reshifting
    exp_mid10 = 4'b0000;
`endif
    do_reset();
    chanx_left_in = onehot(6);
    shift_seq(CFG_A, CFG_W-1, 0);
    total++; if (top_grid_pin !== 4'b1000) begin bad++;
      $display("FAIL reshift_a_pins: got=%b exp=1000", top_grid_pin); end
    shift_seq(CFG_B, CFG_W-1, 8);
    total++; if (config_done !== 1'b0) begin bad++;
      $display("FAIL reshift_mid_done: got=%b exp=0", config_done); end
    total++; if (top_grid_pin !== exp_mid6) begin bad++;
      $display("FAIL reshift_mid_track6: got=%b exp=%b", top_grid_pin, exp_mid6); end
    chanx_left_in = onehot(10); #1;
    total++; if (top_grid_pin !== exp_mid10) begin bad++;
      $display("FAIL reshift_mid_track10: got=%b exp=%b", top_grid_pin, exp_mid10); end
    chanx_left_in = onehot(6);
    shift_seq(CFG_B, 7, 0);
    total++; if (config_done !== 1'b1) begin bad++;
      $display("FAIL reshift_b_done: got=%b exp=1", config_done); end
    total++; if (top_grid_pin !== 4'b0000) begin bad++;
      $display("FAIL reshift_b_track6: got=%b exp=0000", top_grid_pin); end
    chanx_left_in = onehot(10); #1;
    total++; if (top_grid_pin !== 4'b1000) begin bad++;
      $display("FAIL reshift_b_track10: got=%b exp=1000", top_grid_pin); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gating();
    test_tail_latency();
    test_mid_reset();
    test_reshift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
